// File: rtl/he_pkg.sv
// he_pkg: shared constants, scheduler states and the rounding-divide function
// for the homomorphic multiplier back end.
package he_pkg;
    localparam int N       = 1024;
    localparam int ADDR_W  = 10;
    localparam int IN_W    = 120;
    localparam int OUT_W   = 30;
    localparam int SHIFT   = 90;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    // Round half up, then keep the low OUT_W bits; the extra carry bit lets
    // an all-ones input wrap cleanly to zero instead of saturating.
    function automatic logic [OUT_W-1:0] round_div(input logic [IN_W-1:0] a);
        return OUT_W'(({1'b0, a} + ((IN_W + 1)'(1) << (SHIFT - 1))) >> SHIFT);
    endfunction
endpackage

// File: rtl/divround_core.sv
// divround_core: two-stage rounding-divide pipeline; stage 1 aligns address and
// bank with the RAM read latency, stage 2 registers the rounded result.
module divround_core
    import he_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [IN_W-1:0]   a,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              sel_in,
    output logic              valid_out,
    output logic [OUT_W-1:0]  result,
    output logic [ADDR_W-1:0] addr_out,
    output logic              sel_out
);
    logic              v1;
    logic              sel1;
    logic [ADDR_W-1:0] addr1;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            sel1      <= 1'b0;
            addr1     <= '0;
            valid_out <= 1'b0;
            result    <= '0;
            addr_out  <= '0;
            sel_out   <= 1'b0;
        end else begin
            v1        <= valid_in;
            valid_out <= v1;
            if (valid_in) begin
                addr1 <= addr_in;
                sel1  <= sel_in;
            end
            if (v1) begin
                result   <= round_div(a);
                addr_out <= addr1;
                sel_out  <= sel1;
            end
        end
    end
endmodule

// File: rtl/divround_sched.sv
// divround_sched: round-robin scheduler sharing one rounding-divide core between
// two product banks; each job streams N coefficients and pulses done when drained.
module divround_sched
    import he_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [NUM_REQ-1:0] done,
    output logic               rd_en,
    output logic               rd_sel,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [IN_W-1:0]    rd_data,
    output logic               wr_en,
    output logic               wr_sel,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [OUT_W-1:0]   wr_data
);
    state_t             state, state_n;
    logic [ADDR_W-1:0]  cnt, cnt_n;
    logic               owner, owner_n;
    logic               prio, prio_n;
    logic               pick;
    logic [NUM_REQ-1:0] done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            prio  <= 1'b0;
            done  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            owner <= owner_n;
            prio  <= prio_n;
            done  <= done_n;
        end
    end

    // prio names the requester that wins a tie; it flips to the loser at grant.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        owner_n = owner;
        prio_n  = prio;
        done_n  = '0;
        pick    = (&req) ? prio : req[1];
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = STREAM;
                    owner_n = pick;
                    prio_n  = ~pick;
                    cnt_n   = '0;
                end
            end
            STREAM: begin
                cnt_n   = (cnt == ADDR_W'(N - 1)) ? '0 : cnt + 1'b1;
                state_n = (cnt == ADDR_W'(N - 1)) ? DRAIN : STREAM;
            end
            DRAIN: begin
                cnt_n   = (cnt == ADDR_W'(1)) ? '0 : cnt + 1'b1;
                state_n = (cnt == ADDR_W'(1)) ? IDLE : DRAIN;
                done_n  = (cnt == ADDR_W'(1)) ? NUM_REQ'(1) << owner : '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign grant   = busy ? NUM_REQ'(1) << owner : '0;
    assign rd_en   = (state == STREAM);
    assign rd_sel  = owner;
    assign rd_addr = rd_en ? cnt : '0;

    divround_core u_core (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (rd_en),
        .a         (rd_data),
        .addr_in   (rd_addr),
        .sel_in    (rd_sel),
        .valid_out (wr_en),
        .result    (wr_data),
        .addr_out  (wr_addr),
        .sel_out   (wr_sel)
    );
endmodule

// File: tb/tb_divround_sched.sv
// tb_divround_sched: directed bench with hand-computed bank contents and results;
// every cycle of each job is compared against the expected outputs.
module tb_divround_sched;
    localparam int N = 1024;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [1:0]   grant;
    logic         busy;
    logic [1:0]   done;
    logic         rd_en;
    logic         rd_sel;
    logic [9:0]   rd_addr;
    logic [119:0] rd_data;
    logic         wr_en;
    logic         wr_sel;
    logic [9:0]   wr_addr;
    logic [29:0]  wr_data;

    int checks = 0;
    int fails  = 0;

    divround_sched dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_sel  (rd_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    // bank 0: i<<90; bank 1: rounding corner cases at 0..3, (1000+i)<<90 elsewhere
    function automatic logic [119:0] memv(input logic s, input logic [9:0] a);
        if (!s) return {10'd0, a, 100'd0} >> 10;
        case (a)
            10'd0:   return (120'(1) << 89) - 120'(1);
            10'd1:   return 120'(1) << 89;
            10'd2:   return 120'(3) << 89;
            10'd3:   return {120{1'b1}};
            default: return 120'(1000 + int'(a)) << 90;
        endcase
    endfunction

    function automatic logic [29:0] expv(input logic s, input int a);
        if (!s) return 30'(a);
        case (a)
            0:       return 30'd0;
            1:       return 30'd1;
            2:       return 30'd2;
            3:       return 30'd0;
            default: return 30'(1000 + a);
        endcase
    endfunction

    always @(posedge clk) rd_data <= rd_en ? memv(rd_sel, rd_addr) : '0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [58:0] obs_vec();
        return {grant, busy, rd_en, rd_en ? {rd_sel, rd_addr} : 11'd0,
                wr_en, wr_en ? {wr_sel, wr_addr, wr_data} : 41'd0, done};
    endfunction

    function automatic logic [58:0] raw_vec();
        return {grant, busy, rd_en, rd_sel, rd_addr, wr_en, wr_sel, wr_addr, wr_data, done};
    endfunction

    // Entered at the negedge of the first granted cycle; runs through the done cycle
    // (c = N+2) unless stopped early at c = last.
    task automatic run_job(input logic o, input int raise_at, input int last);
        logic [1:0]  g;
        logic [58:0] e;
        for (int c = 0; c <= last; c++) begin
            if (c == raise_at) req[1] = 1'b1;
            g = (c <= N + 1) ? 2'(1) << o : 2'b00;
            e = {g, c <= N + 1, c < N,
                 c < N ? {o, 10'(c)} : 11'd0,
                 c >= 2 && c <= N + 1,
                 (c >= 2 && c <= N + 1) ? {o, 10'(c - 2), expv(o, c - 2)} : 41'd0,
                 c == N + 2 ? 2'(1) << o : 2'b00};
            chk($sformatf("job%0d_c%0d", o, c), 64'(obs_vec()), 64'(e));
            if (c < last) @(negedge clk);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk(tag, 64'(obs_vec()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'(raw_vec()), 64'd0);
        reset = 1'b0;

        // single job on bank 0
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        run_job(1'b0, -1, N + 2);
        @(negedge clk);
        idle_chk("after_job0");

        // rounding corners on bank 1
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        run_job(1'b1, -1, N + 2);
        @(negedge clk);
        idle_chk("after_round");

        // contention from reset: 0, then 1, then 0 again
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 2'b11;
        @(negedge clk);
        run_job(1'b0, -1, N + 2);
        @(negedge clk);
        run_job(1'b1, -1, N + 2);
        @(negedge clk);
        run_job(1'b0, -1, N + 2);
        req = 2'b00;
        @(negedge clk);
        idle_chk("after_rr");

        // request arriving mid-job is held off until the job finishes
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        run_job(1'b0, 499, N + 2);
        @(negedge clk);
        req = 2'b00;
        run_job(1'b1, -1, N + 2);
        @(negedge clk);
        idle_chk("after_midreq");

        // reset mid-job kills the pipeline
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        run_job(1'b0, -1, 599);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_state", 64'(raw_vec()), 64'd0);
        @(negedge clk);
        idle_chk("midreset_p1");
        @(negedge clk);
        idle_chk("midreset_p2");
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        run_job(1'b1, -1, N + 2);

        // back-to-back jobs for a held request
        req = 2'b01;
        @(negedge clk);
        run_job(1'b0, -1, N + 2);
        @(negedge clk);
        run_job(1'b0, -1, N + 2);
        req = 2'b00;
        @(negedge clk);
        idle_chk("after_b2b");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/divround_sched.md
Name: divround_sched

Overview:
- Scheduler that shares one rounding-divide datapath (round(a / 2^SHIFT)) between two requesters, e.g. the two tensor-product output banks of the polynomial multiplier.
- A granted job streams all N coefficients of the requester's product bank through the rounding core and writes the results to that requester's result bank.
- Sits between the multiplier's product RAMs and the relinearisation/result RAMs.
- Replaces free-running per-bank rounding with a start/grant/done-sequenced shared unit.

Parameters:
- N, 1024, coefficients per polynomial (job length)
- ADDR_W, 10, coefficient address width, clog2(N)
- IN_W, 120, product coefficient width
- OUT_W, 30, rounded result width
- SHIFT, 90, divisor exponent (divide by 2^SHIFT)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  2  level job request per requester; sampled only in IDLE
- grant  out  2  one-hot owner of current job; held for whole job
- busy  out  1  high while a job is in flight (STREAM or DRAIN)
- done  out  2  one-cycle pulse to the finished requester
- rd_en  out  1  product RAM read strobe
- rd_sel  out  1  product bank select (requester index)
- rd_addr  out  ADDR_W  coefficient read address
- rd_data  in  IN_W  product data; valid exactly 1 cycle after rd_en
- wr_en  out  1  result RAM write strobe
- wr_sel  out  1  result bank select
- wr_addr  out  ADDR_W  coefficient write address
- wr_data  out  OUT_W  rounded coefficient

Behaviour:
- Reset: clk rising edge with reset=1 clears the following, even mid-job, and discards in-flight pipeline writes (wr_en=0 from the next cycle):
  - grant, done, busy, rd_en, wr_en, rd_addr, wr_addr, wr_data, rd_sel, wr_sel = 0
  - state = IDLE
  - counter = 0
  - rr pointer = 0, so requester 0 wins the first tie
- States: IDLE -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - If any req bit is set, grant one and go to STREAM.
  - Single request: grant it.
  - Both requests: grant the requester that was not granted last (round-robin; pointer updates at grant).
- STREAM:
  - rd_en=1, rd_addr=cnt, rd_sel=owner for cnt = 0..N-1, one per cycle, no gaps.
  - After cnt=N-1, cnt wraps to 0 and the FSM goes to DRAIN.
- Pipeline, fixed latency 2 from rd_en to wr_en:
  - Cycle k: read issued.
  - Cycle k+1: rd_data registered into the core.
  - Cycle k+2: wr_en=1, wr_addr=address read at k, wr_sel=owner, wr_data=result.
- DRAIN: 2 cycles, rd_en=0; the last two writes complete.
- Job completion:
  - On leaving DRAIN, the FSM enters IDLE with grant=0 and done[owner]=1 for exactly that cycle.
  - Arbitration resumes in that same IDLE cycle.
- Timing for a req first seen at cycle 0:
  - grant/busy at cycle 1
  - reads at cycles 1..N
  - writes at cycles 3..N+2
  - done at cycle N+3
  - earliest next grant at cycle N+4
- req changes during a job are ignored.
- A requester still holding req after its done pulse is treated as a new request, subject to round-robin.
- Arithmetic:
  - Compute sum = rd_data + 2^(SHIFT-1) in IN_W+1 bits.
  - result = (sum >> SHIFT) mod 2^OUT_W, i.e. round-half-up, truncated.
  - rd_data = all ones rounds to 2^OUT_W, which truncates to 0 (defined wrap, no saturation).

Decomposition:
- Shared package `he_pkg`:
  - N, ADDR_W, IN_W, OUT_W, SHIFT constants
  - state enum {IDLE, STREAM, DRAIN}
  - NUM_REQ=2
- Sub-module `divround_core` (pipelined rounding-divide):
  - in: clk, reset, valid_in, a[IN_W], addr_in, sel_in
  - out: valid_out, result[OUT_W], addr_out, sel_out
  - registered, latency 2 from rd_en as above
  - the scheduler owns the FSM, arbiter and counter

Test Plan:
1. Single job: req=01 held 1 cycle, bank0[i]=i<<90 -> grant=01 at cycle 1, 1024 writes wr_sel=0 wr_data[i]=i at cycles 3..1026, done=01 at cycle 1027, busy low after.
2. Rounding: rd_data=2^89-1 -> 0; 2^89 -> 1; 3·2^89 -> 2; all-ones 120-bit -> 0 (wrap).
3. Contention: req=11 from reset -> requester 0 job, then requester 1 job granted at cycle 1028, done=10 at 2054; req=11 again -> requester 0 next (round-robin alternates).
4. Request during job: raise req[1] at cycle 500 of requester 0 job -> no grant change, no extra writes; requester 1 granted at cycle N+4.
5. Reset mid-job: assert reset at cycle 600 for 1 cycle -> next cycle all outputs 0, no wr_en for the pending two addresses; req=10 afterwards -> fresh job starting at address 0 for requester 1.
6. Back-to-back same requester: req[0] held high continuously, req[1]=0 -> jobs re-granted every N+3 cycles, done pulses exactly 1 cycle wide, addresses restart at 0 each job.
